// File: rtl/bram_port_ctrl.sv
// Client-side port controller for a single-port BRAM: request stream to BRAM cycles, read data after 2 cycles.
// Read responses are buffered in a 2-entry FIFO, and request acceptance stalls while that buffer is full; the bulk-clear sweep blocks requests.
module bram_port_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  clr_start,
  input  logic [DATA_WIDTH-1:0] clr_value,
  output logic                  busy,
  output logic                  clr_done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] clr_val_q, clr_val_d;
  logic                  clr_done_q, clr_done_d;
  logic                  rd_pend_q, rd_pend_d;

  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q, count_d;

  logic                  is_idle;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [1:0]            slots_used;

  // An issued read reserves its FIFO slot so the BRAM data always has somewhere to land.
  always_comb begin
    is_idle    = (state_q == ST_IDLE);
    slots_used = count_q + {1'b0, rd_pend_q};
    req_ready  = reset_n && is_idle && !clr_start && (slots_used < 2'd2);
    accept     = req_valid && req_ready;
    rd_pend_d  = accept && !req_we;
    push       = rd_pend_q;
    rsp_valid  = (count_q != 2'd0);
    rsp_rdata  = fifo_q[rd_ptr_q];
    pop        = rsp_valid && rsp_ready;
    busy       = (state_q == ST_CLEAR);
    clr_done   = clr_done_q;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_val_d  = clr_val_q;
    clr_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d   = ST_CLEAR;
          cnt_d     = '0;
          clr_val_d = clr_value;
        end
      end
      default: begin
        cnt_d = cnt_q + ADDR_ONE;
        if (cnt_q == LAST_ADDR) begin
          state_d    = ST_IDLE;
          clr_done_d = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    if (state_q == ST_CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = cnt_q;
      mem_din  = clr_val_q;
    end else begin
      mem_we   = accept && req_we;
      mem_addr = req_addr;
      mem_din  = req_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      clr_val_q  <= '0;
      clr_done_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_val_q  <= clr_val_d;
      clr_done_q <= clr_done_d;
      rd_pend_q  <= rd_pend_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem_dout;
  end

endmodule

// File: tb/tb_bram_port_ctrl.sv
// Directed bench for bram_port_ctrl with a behavioural write-first BRAM attached.
module tb_bram_port_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          clr_start;
  logic [DW-1:0] clr_value;
  logic          busy, clr_done;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  logic [DW-1:0] bram [16];

  int n_checks = 0;
  int n_fail   = 0;

  bram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .clr_start(clr_start), .clr_value(clr_value),
    .busy(busy), .clr_done(clr_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      bram[mem_addr] <= mem_din;
      mem_dout       <= mem_din;
    end else begin
      mem_dout <= bram[mem_addr];
    end
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    #1;
    while (!req_ready && t < 20) begin
      @(negedge clk); #1; t++;
    end
    if (!req_ready) begin
      $display("FAIL write_accept_timeout addr=%0d ready=%b want 1", a, req_ready);
      n_fail++;
    end
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic ok);
    int t = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    #1;
    while (!req_ready && t < 20) begin
      @(negedge clk); #1; t++;
    end
    ok = req_ready;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    t = 0;
    while (!rsp_valid && t < 10) begin
      @(negedge clk); #1; t++;
    end
    ok = ok && rsp_valid;
    d  = rsp_rdata;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = '0; req_wdata = 8'hFF;
    rsp_ready = 1'b1; clr_start = 1'b0; clr_value = '0;
    #2;
    n_checks++;
    if (req_ready !== 1'b0) begin $display("FAIL reset_req_ready got=%b want=0", req_ready); n_fail++; end
    n_checks++;
    if (mem_we !== 1'b0) begin $display("FAIL reset_mem_we got=%b want=0", mem_we); n_fail++; end
    n_checks++;
    if ({rsp_valid, busy, clr_done} !== 3'b000)
      begin $display("FAIL reset_outputs rsp_valid/busy/clr_done got=%b want=000", {rsp_valid, busy, clr_done}); n_fail++; end
    req_valid = 1'b0; req_we = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 8'hA5;
    #1;
    n_checks++;
    if ({req_ready, mem_we, mem_addr, mem_din} !== {1'b1, 1'b1, 4'd3, 8'hA5})
      begin $display("FAIL wr_issue ready=%b we=%b addr=%0d din=%h want 1 1 3 a5", req_ready, mem_we, mem_addr, mem_din); n_fail++; end
    @(negedge clk);
    req_we = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, mem_we} !== 2'b10)
      begin $display("FAIL rd_issue ready=%b we=%b want ready=1 we=0", req_ready, mem_we); n_fail++; end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin $display("FAIL rd_lat1 rsp_valid got=%b want=0", rsp_valid); n_fail++; end
    @(negedge clk); #1;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5)
      begin $display("FAIL rd_lat2 valid=%b data=%h want 1 a5", rsp_valid, rsp_rdata); n_fail++; end
    @(negedge clk); #1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin $display("FAIL rd_popped rsp_valid got=%b want=0", rsp_valid); n_fail++; end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] got [3];
    int n = 0;
    int t = 0;
    logic acc;
    do_write(4'd0, 8'h10);
    do_write(4'd1, 8'h11);
    do_write(4'd2, 8'h12);
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin $display("FAIL bp_rd0_ready got=%b want=1", req_ready); n_fail++; end
    @(negedge clk);
    req_addr = 4'd1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin $display("FAIL bp_rd1_ready got=%b want=1", req_ready); n_fail++; end
    @(negedge clk);
    req_addr = 4'd2;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin $display("FAIL bp_rd2_stall got=%b want=0", req_ready); n_fail++; end
    repeat (3) begin @(negedge clk); #1; end
    n_checks++;
    if ({req_ready, rsp_valid, rsp_rdata} !== {1'b0, 1'b1, 8'h10})
      begin $display("FAIL bp_hold ready=%b valid=%b data=%h want 0 1 10", req_ready, rsp_valid, rsp_rdata); n_fail++; end
    rsp_ready = 1'b1;
    while (n < 3 && t < 12) begin
      acc = req_valid && req_ready;
      if (rsp_valid) begin got[n] = rsp_rdata; n++; end
      @(negedge clk);
      if (acc) req_valid = 1'b0;
      #1;
      t++;
    end
    req_valid = 1'b0;
    n_checks++;
    if (n !== 3) begin $display("FAIL bp_count got=%0d want=3", n); n_fail++; end
    else begin
      n_checks++;
      if (got[0] !== 8'h10 || got[1] !== 8'h11 || got[2] !== 8'h12)
        begin $display("FAIL bp_order got=%h %h %h want 10 11 12", got[0], got[1], got[2]); n_fail++; end
    end
  endtask

  task automatic test_clear();
    logic [DW-1:0] d;
    logic ok;
    int bad = 0;
    @(negedge clk);
    clr_start = 1'b1; clr_value = 8'h3C;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 8'hEE;
    #1;
    n_checks++;
    if ({req_ready, mem_we} !== 2'b00)
      begin $display("FAIL clr_prio ready=%b we=%b want 0 0", req_ready, mem_we); n_fail++; end
    @(negedge clk);
    clr_start = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 7) begin clr_start = 1'b1; clr_value = 8'h55; end
      if (i == 8) clr_start = 1'b0;
      #1;
      n_checks++;
      if ({busy, mem_we, mem_addr, mem_din, clr_done} !== {1'b1, 1'b1, i[3:0], 8'h3C, 1'b0})
        begin $display("FAIL clr_cycle%0d busy=%b we=%b addr=%0d din=%h done=%b want 1 1 %0d 3c 0",
                       i, busy, mem_we, mem_addr, mem_din, clr_done, i); n_fail++; end
      @(negedge clk);
    end
    clr_start = 1'b0;
    #1;
    n_checks++;
    if ({busy, clr_done} !== 2'b01)
      begin $display("FAIL clr_end busy=%b done=%b want 0 1", busy, clr_done); n_fail++; end
    @(negedge clk); #1;
    n_checks++;
    if (clr_done !== 1'b0) begin $display("FAIL clr_done_pulse got=%b want=0", clr_done); n_fail++; end
    for (int a = 0; a < 16; a++) begin
      do_read(a[3:0], d, ok);
      if (!ok || d !== 8'h3C) begin
        $display("FAIL clr_readback addr=%0d ok=%b got=%h want=3c", a, ok, d);
        bad++;
      end
    end
    n_checks++;
    if (bad != 0) n_fail++;
  endtask

  task automatic test_read_before_clear();
    int t = 0;
    do_write(4'd9, 8'h77);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd9;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin $display("FAIL rbc_accept got=%b want=1", req_ready); n_fail++; end
    @(negedge clk);
    req_valid = 1'b0; clr_start = 1'b1; clr_value = 8'h00;
    @(negedge clk);
    clr_start = 1'b0;
    #1;
    n_checks++;
    if ({busy, rsp_valid, rsp_rdata} !== {1'b1, 1'b1, 8'h77})
      begin $display("FAIL rbc_rsp busy=%b valid=%b data=%h want 1 1 77", busy, rsp_valid, rsp_rdata); n_fail++; end
    while (!clr_done && t < 40) begin @(negedge clk); #1; t++; end
    n_checks++;
    if (clr_done !== 1'b1) begin $display("FAIL rbc_done_timeout got=%b want=1", clr_done); n_fail++; end
  endtask

  task automatic test_reset_mid_clear();
    logic [DW-1:0] d, exp;
    logic ok;
    logic [3:0] addr;
    int bad = 0;
    int dn = 0;
    for (int a = 0; a < 16; a++) begin
      addr = a[3:0];
      do_write(addr, {4'h8, addr});
    end
    @(negedge clk);
    clr_start = 1'b1; clr_value = 8'hE1;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if ({busy, mem_addr} !== {1'b1, 4'd5})
      begin $display("FAIL rmc_pre busy=%b addr=%0d want 1 5", busy, mem_addr); n_fail++; end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, mem_we, clr_done} !== 3'b000)
      begin $display("FAIL rmc_abort busy=%b we=%b done=%b want 0 0 0", busy, mem_we, clr_done); n_fail++; end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      #1;
      if (clr_done !== 1'b0) dn++;
      @(negedge clk);
    end
    n_checks++;
    if (dn != 0) begin $display("FAIL rmc_no_done pulses=%0d want 0", dn); n_fail++; end
    for (int a = 0; a < 16; a++) begin
      addr = a[3:0];
      exp  = (a < 5) ? 8'hE1 : {4'h8, addr};
      do_read(addr, d, ok);
      if (!ok || d !== exp) begin
        $display("FAIL rmc_readback addr=%0d ok=%b got=%h want=%h", a, ok, d, exp);
        bad++;
      end
    end
    n_checks++;
    if (bad != 0) n_fail++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) bram[i] = '0;
    mem_dout = '0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_clear();
    test_read_before_clear();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bram_port_ctrl.md
Name: bram_port_ctrl

Overview:
Initiator-side controller for the single-port synchronous BRAM (1-cycle registered read, write-first-cycle port). Converts a valid/ready request stream into BRAM port cycles, returns read data on a valid/ready response stream with backpressure buffering, and provides a bulk-clear engine that sweeps every address with a fill value. Sits between a client (CPU bus bridge / test FSM) and the BRAM instance.

Parameters:
ADDR_WIDTH, 10, BRAM address width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 8, BRAM word width

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller accepts request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  read data available
rsp_ready  in  1  client takes read data
rsp_rdata  out  DATA_WIDTH  read data
clr_start  in  1  single-cycle pulse: begin bulk clear
clr_value  in  DATA_WIDTH  fill value, sampled with clr_start
busy  out  1  clear in progress
clr_done  out  1  single-cycle pulse: clear finished
mem_we  out  1  to BRAM we
mem_addr  out  ADDR_WIDTH  to BRAM addr_a
mem_din  out  DATA_WIDTH  to BRAM din_a
mem_dout  in  DATA_WIDTH  from BRAM dout_a

Behaviour:
- Reset (async, reset_n=0): state IDLE, rsp FIFO empty, rd_pend=0, clear counter 0; outputs req_ready=0 during reset, rsp_valid=0, busy=0, clr_done=0, mem_we=0. Memory contents untouched by reset.
- FSM: IDLE, CLEAR.
  - IDLE->CLEAR on clr_start=1; latch clr_value, counter=0.
  - CLEAR->IDLE after writing address 2**ADDR_WIDTH-1; clr_done=1 for exactly the first cycle back in IDLE.
  - clr_start in CLEAR ignored.
- Response path: 2-entry FIFO plus rd_pend flag (read issued, data not yet captured).
- req_ready = (state==IDLE) && !clr_start && (fifo_count + rd_pend < 2). clr_start has priority over a same-cycle request.
- Accept = req_valid && req_ready. mem_addr/mem_din/mem_we are combinational from request fields on accept. mem_we = accept && req_we; mem_addr driven with req_addr whenever IDLE.
- Read accepted in cycle T: rd_pend=1 after edge T. mem_dout valid during T+1; pushed into FIFO at edge T+1. rsp_valid=1 from T+2 (fixed latency 2 with empty FIFO and rsp_ready=1).
- Write: no response. Zero-latency accept; back-to-back accepts, one per cycle, when slots allow.
- FIFO pop when rsp_valid && rsp_ready. Push and pop in the same cycle are legal; count unchanged. Order preserved.
- CLEAR: mem_we=1, mem_addr=counter, mem_din=latched value, counter+1 per cycle. Duration is exactly 2**ADDR_WIDTH cycles. busy=1 throughout. The counter wraps to 0 on exit.
- Reads in flight at clr_start complete normally, because they sample before the first clear write. The FIFO keeps draining during CLEAR.
- Reset mid-CLEAR: abort immediately. Partial fill remains in memory, no clr_done, busy=0.

Test Plan:
- ADDR_WIDTH=4, DATA_WIDTH=8. Write 0xA5@3, then read @3 -> rsp_valid at accept+2, rsp_rdata=0xA5; mem_we high exactly 1 cycle.
- rsp_ready=0, issue 3 reads @0,@1,@2 (values 0x10,0x11,0x12) -> only 2 accepted; req_ready=0 until a pop. Release rsp_ready -> data returned 0x10,0x11,0x12 in order.
- clr_start with clr_value=0x3C -> busy=1 for 16 cycles, mem_addr 0..15, clr_done one cycle. Subsequent reads of all 16 addresses return 0x3C.
- req_valid and clr_start asserted in the same cycle -> request not accepted; CLEAR entered. clr_start pulsed again mid-clear -> ignored, still 16 cycles total.
- Read accepted 1 cycle before clr_start on an address holding 0x77 -> response 0x77 delivered during CLEAR.
- reset_n low at clear cycle 5 -> busy=0 immediately, no clr_done. Addresses 0..4 hold the fill value; 5..15 keep their old values.
